// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The index width function keeps widths at least one bit wide for any count.
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int idw_f(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req bit searching upward from ptr+1 with wrap.
// Pure logic, no state; found is low when req is all-zero.
module rr_pick
   import rr_arbiter_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = idw_f(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] idx
);

   // Each requester's distance from ptr+1 around the ring; the closest set bit wins.
   always_comb begin
      int best;
      found = 1'b0;
      idx   = '0;
      best  = N;
      for (int j = 0; j < N; j++) begin
         int d;
         d = (j + 2 * N - 1 - int'(ptr)) % N;
         if (req[j] && (d < best)) begin
            best  = d;
            found = 1'b1;
            idx   = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, N requesters, registered one-hot grant one edge after req; holder locks the grant.
// Requesters wait for gnt; RR_ARB_HOLD_LIMIT_EN forces rotation after MAX_HOLD cycles if others wait.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16,
   parameter int IDW      = idw_f(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id
);

   if (N < 2 || MAX_HOLD < 2) begin : g_param_err
      $error("rr_arbiter: N and MAX_HOLD must both be at least 2");
   end

   localparam logic [N-1:0] ONE = N'(1);

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [N-1:0]   cand;
   logic           found;
   logic [IDW-1:0] pick_idx;
   logic           holder_req;
   logic           rotate;
   logic           take;
   logic           leave;

   // Masking out the holder serves all three cases: idle (gnt=0), release and forced rotation.
   assign cand       = req & ~gnt;
   assign holder_req = |(req & gnt);

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req   (cand),
      .ptr   (ptr),
      .found (found),
      .idx   (pick_idx)
   );

`ifdef RR_ARB_HOLD_LIMIT_EN
   localparam int CW = idw_f(MAX_HOLD);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   logic [CW-1:0] hold_cnt;

   assign rotate = (hold_cnt == HOLD_LAST) && found;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt <= '0;
      end else if (take) begin
         hold_cnt <= '0;
      end else if (state == BUSY && hold_cnt != HOLD_LAST) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end
`else
   assign rotate = 1'b0;
`endif

   always_comb begin
      take  = 1'b0;
      leave = 1'b0;
      case (state)
         IDLE: take = found;
         BUSY: begin
            if (holder_req) begin
               take = rotate;
            end else begin
               take  = found;
               leave = !found;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= IDW'(N - 1);
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
      end else if (take) begin
         state     <= BUSY;
         ptr       <= pick_idx;
         gnt       <= ONE << pick_idx;
         gnt_valid <= 1'b1;
         gnt_id    <= pick_idx;
      end else if (leave) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios with literal expectations plus sticky random requests
// checked every cycle against a queue-free behavioural ring-search model.
module tb_rr_arbiter;

   localparam int N    = 4;
   localparam int MAXH = 4;
   localparam int IDW  = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;

   int vectors    = 0;
   int miscompares = 0;

   // Model state: current holder (-1 none), last granted index, visible gnt_id, cycles held.
   int m_holder = -1;
   int m_last   = N - 1;
   int m_id     = 0;
   int m_held   = 0;

   rr_arbiter #(
      .N        (N),
      .MAX_HOLD (MAXH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int search(input logic [N-1:0] r, input int from, input int excl);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (from + k) % N;
         if (c != excl && ((r >> c) & 1) != 0) return c;
      end
      return -1;
   endfunction

   task automatic model_grant(input int c);
      m_holder = c;
      m_last   = c;
      m_id     = c;
      m_held   = 1;
   endtask

   task automatic model_step(input logic [N-1:0] r);
      int nxt;
      if (m_holder >= 0 && ((r >> m_holder) & 1) != 0) begin
         nxt = -1;
`ifdef RR_ARB_HOLD_LIMIT_EN
         if (m_held >= MAXH) nxt = search(r, m_last, m_holder);
`endif
         if (nxt >= 0) model_grant(nxt);
         else m_held++;
      end else begin
         nxt = search(r, m_last, -1);
         if (nxt >= 0) model_grant(nxt);
         else m_holder = -1;
      end
   endtask

   always @(negedge rst) begin
      m_holder = -1;
      m_last   = N - 1;
      m_id     = 0;
      m_held   = 0;
   end

   // Per-cycle compare of every output against the model.
   always @(posedge clk) begin
      logic [N-1:0] eg;
      if (rst === 1'b1) model_step(req);
      #1;
      eg = (m_holder >= 0) ? (N'(1) << m_holder) : '0;
      chk("model_gnt", gnt, eg);
      chk("model_valid", gnt_valid, (m_holder >= 0));
      chk("model_id", gnt_id, m_id);
   end

   task automatic step(input logic [N-1:0] r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", gnt_valid, 0);
      chk("rst_id", gnt_id, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [N-1:0] exp;
      logic [N-1:0] flip;
      rst = 1'b0;
      req = '0;
      #12;

      // Reset, then release with no requests.
      do_reset();
      step(4'b0000);
      step(4'b0000);
      chk("idle_gnt", gnt, 0);
      chk("idle_valid", gnt_valid, 0);

      // Single requests, immediate handover from the previous holder.
      step(4'b0001); chk("single_gnt0", gnt, 4'b0001); chk("single_id0", gnt_id, 0);
      step(4'b0100); chk("single_gnt2", gnt, 4'b0100); chk("single_id2", gnt_id, 2);
      step(4'b0010); chk("single_gnt1", gnt, 4'b0010); chk("single_id1", gnt_id, 1);
      step(4'b1000); chk("single_gnt3", gnt, 4'b1000); chk("single_id3", gnt_id, 3);
      chk("pin_model_id3", m_id, 3);
      step(4'b0000); chk("single_drop", gnt_valid, 0); chk("single_id_hold", gnt_id, 3);

      // All requesting, each holder drops for one cycle after its grant.
      do_reset();
      step(4'b1111); chk("fair_0", gnt_id, 0); chk("fair_v0", gnt_valid, 1);
      step(4'b1110); chk("fair_1", gnt_id, 1); chk("fair_v1", gnt_valid, 1);
      step(4'b1101); chk("fair_2", gnt_id, 2); chk("fair_v2", gnt_valid, 1);
      step(4'b1011); chk("fair_3", gnt_id, 3); chk("fair_v3", gnt_valid, 1);
      step(4'b0111); chk("fair_4", gnt_id, 0); chk("fair_v4", gnt_valid, 1);
      chk("pin_model_fair", m_last, 0);

      // Lock with a competing requester; rotation every MAXH cycles only with the hold limit.
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step(4'b0011);
`ifdef RR_ARB_HOLD_LIMIT_EN
         exp = (((k - 1) / MAXH) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
         exp = 4'b0001;
`endif
         chk("lock_gnt", gnt, exp);
      end
      step(4'b0010);
      chk("lock_release", gnt, 4'b0010);

      // Lone holder never loses the grant.
      do_reset();
      for (int k = 0; k < 12; k++) begin
         step(4'b0001);
         chk("lone_hold", gnt, 4'b0001);
      end

      // Asynchronous reset while requester 2 holds the grant.
      do_reset();
      step(4'b0100);
      chk("mid_pre", gnt, 4'b0100);
      #1;
      rst = 1'b0;
      #1;
      chk("mid_async_gnt", gnt, 0);
      chk("mid_async_valid", gnt_valid, 0);
      chk("mid_async_id", gnt_id, 0);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b1111;
      @(posedge clk);
      #2;
      chk("mid_restart", gnt, 4'b0001);

      // Sticky random requests with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst  = ($urandom_range(0, 299) != 0);
         flip = N'($urandom & $urandom);
         req  = req ^ flip;
      end
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
